// File: rtl/division_float_param_if.sv
// Start/finish handshake and operand/result bundle for division_float_param.
// The overflow/underflow flags exist only when FLOAT_DIV_FLAGS_EN is defined.
interface division_float_param_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic [W-1:0] result;
  logic         finish;
  logic         illegal;
  logic         busy;

`ifdef FLOAT_DIV_FLAGS_EN
  logic overflow;
  logic underflow;

  modport master (
    output start, operand1, operand2,
    input  result, finish, illegal, busy, overflow, underflow
  );
  modport slave (
    input  start, operand1, operand2,
    output result, finish, illegal, busy, overflow, underflow
  );
`else
  modport master (
    output start, operand1, operand2,
    input  result, finish, illegal, busy
  );
  modport slave (
    input  start, operand1, operand2,
    output result, finish, illegal, busy
  );
`endif
endinterface

// File: rtl/division_float_param.sv
// Iterative restoring floating-point divider, RNE rounding, FTZ, fixed latency.
// Define FLOAT_DIV_FLAGS_EN to build the overflow/underflow status flags.
module division_float_param #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic                   clock,
  input logic                   reset,
  division_float_param_if.slave bus
);
  localparam int unsigned W         = 1 + EXP_W + MAN_W;
  localparam int unsigned EW        = EXP_W + 2;
  localparam int unsigned DivCycles = MAN_W + 3;
  localparam int unsigned CntW      = $clog2(DivCycles);
  localparam logic [EW-1:0]    Bias    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EXP_W-1:0] ExpOnes = '1;

  typedef enum logic [2:0] {StIdle, StUnpack, StDivide, StNorm, StRound, StDone} state_e;
  typedef enum logic [1:0] {SpNone, SpNan, SpInf, SpZero} special_e;

  state_e state_q, state_d;

  logic [W-1:0]     a_q, b_q;
  logic             sign_q;
  special_e         special_q;
  logic             special_ill_q;
  logic [MAN_W+1:0] rem_q;
  logic [MAN_W:0]   div_q;
  logic [MAN_W+2:0] quo_q;
  logic             sticky_q;
  logic [CntW-1:0]  cnt_q;
  logic [EW-1:0]    e_q;
  logic [W-1:0]     result_q;
  logic             illegal_q;

  // Operand classification (exponent field 0 is zero, denormals included)
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  special_e sp;
  logic     sp_ill;

  assign e1 = a_q[W-2:MAN_W];
  assign f1 = a_q[MAN_W-1:0];
  assign e2 = b_q[W-2:MAN_W];
  assign f2 = b_q[MAN_W-1:0];

  always_comb begin
    a_zero = (e1 == '0);
    a_inf  = (e1 == ExpOnes) && (f1 == '0);
    a_nan  = (e1 == ExpOnes) && (f1 != '0);
    b_zero = (e2 == '0);
    b_inf  = (e2 == ExpOnes) && (f2 == '0);
    b_nan  = (e2 == ExpOnes) && (f2 != '0);
    sp     = SpNone;
    sp_ill = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp     = SpNan;
      sp_ill = 1'b1;
    end else if (b_zero && !a_inf) begin
      sp     = SpInf;
      sp_ill = 1'b1;
    end else if (a_inf) begin
      sp = SpInf;
    end else if (b_inf || a_zero) begin
      sp = SpZero;
    end
  end

  // One restoring step: remainder always stays below twice the divisor
  logic           rem_ge;
  logic [MAN_W:0] rem_sub;

  always_comb begin
    rem_ge  = (rem_q >= {1'b0, div_q});
    rem_sub = rem_ge ? (MAN_W + 1)'(rem_q - {1'b0, div_q}) : rem_q[MAN_W:0];
  end

  // Rounding on the normalised quotient: hidden bit at MSB, then guard and round bits
  logic [MAN_W:0]  frac_sum;
  logic            round_up;
  logic            carry;
  logic [EW-1:0]   e_rnd;
  logic            ovf, unf;
  logic [W-1:0]    res_comb;

  always_comb begin
    round_up = quo_q[1] && (quo_q[0] || sticky_q || quo_q[2]);
    frac_sum = {1'b0, quo_q[MAN_W+1:2]} + {{MAN_W{1'b0}}, round_up};
    carry    = frac_sum[MAN_W];
    e_rnd    = e_q + {{(EW-1){1'b0}}, carry};
    ovf      = !e_rnd[EW-1] && (e_rnd[EXP_W:0] >= {1'b0, ExpOnes});
    unf      = e_rnd[EW-1] || (e_rnd == '0);
    res_comb = '0;
    unique case (special_q)
      SpNan:  res_comb = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};
      SpInf:  res_comb = {sign_q, ExpOnes, {MAN_W{1'b0}}};
      SpZero: res_comb = {sign_q, {(W-1){1'b0}}};
      SpNone: begin
        if (ovf) begin
          res_comb = {sign_q, ExpOnes, {MAN_W{1'b0}}};
        end else if (unf) begin
          res_comb = {sign_q, {(W-1){1'b0}}};
        end else begin
          res_comb = {sign_q, e_rnd[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StUnpack;
      StUnpack: state_d = StDivide;
      StDivide: if (cnt_q == CntW'(DivCycles - 1)) state_d = StNorm;
      StNorm:   state_d = StRound;
      StRound:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      special_q     <= SpNone;
      special_ill_q <= 1'b0;
      rem_q         <= '0;
      div_q         <= '0;
      quo_q         <= '0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
      e_q           <= '0;
      result_q      <= '0;
      illegal_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q <= bus.operand1;
            b_q <= bus.operand2;
          end
        end
        StUnpack: begin
          sign_q        <= a_q[W-1] ^ b_q[W-1];
          special_q     <= sp;
          special_ill_q <= sp_ill;
          rem_q         <= {2'b01, f1};
          div_q         <= {1'b1, f2};
          quo_q         <= '0;
          cnt_q         <= '0;
          e_q           <= {2'b00, e1} - {2'b00, e2} + Bias;
        end
        StDivide: begin
          rem_q <= {rem_sub, 1'b0};
          quo_q <= {quo_q[MAN_W+1:0], rem_ge};
          cnt_q <= cnt_q + 1'b1;
        end
        StNorm: begin
          sticky_q <= (rem_q != '0);
          if (!quo_q[MAN_W+2]) begin
            quo_q <= {quo_q[MAN_W+1:0], 1'b0};
            e_q   <= e_q - {{(EW-1){1'b0}}, 1'b1};
          end
        end
        StRound: begin
          result_q  <= res_comb;
          illegal_q <= special_ill_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;
  assign bus.finish  = (state_q == StDone);
  assign bus.busy    = (state_q != StIdle);

`ifdef FLOAT_DIV_FLAGS_EN
  logic den_q, overflow_q, underflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      den_q       <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (state_q == StUnpack) begin
      // Denormal dividend over a normal divisor: the true quotient was nonzero
      den_q <= a_zero && (f1 != '0) && !b_zero && (e2 != ExpOnes);
    end else if (state_q == StRound) begin
      overflow_q  <= (special_q == SpNone) && ovf;
      underflow_q <= ((special_q == SpNone) && !ovf && unf) || den_q;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule
